frame_select_ctrl: RTL

//  Upstream controller for the display frame multiplexer. Generates the one-hot

---
 rtl/frame_select_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/frame_select_ctrl.sv
// frame_select_ctrl: raster counters, ping-pong buffer selection and pixel
// read address for the display frame multiplexer. The displayed buffer only
// changes at a frame boundary after the writer has reported a finished frame.
module frame_select_ctrl #(
    parameter int H_ACTIVE = 8,
    parameter int H_TOTAL  = 10,
    parameter int V_ACTIVE = 6,
    parameter int V_TOTAL  = 8,
    parameter int ADDR_W   = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              WrDone,
    output logic              SelBuf0,
    output logic              SelBuf1,
    output logic              SelBlank,
    output logic [ADDR_W-1:0] RdAddr,
    output logic [15:0]       HCount,
    output logic [15:0]       VCount,
    output logic              FrameStart,
    output logic              SwapAck
);

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);

    typedef enum logic {
        S_NOFRAME = 1'b0,
        S_RUN     = 1'b1
    } state_t;

    state_t            state_q;
    logic              disp_q;
    logic              pend_q;
    logic [15:0]       hcnt_q, vcnt_q;
    logic [ADDR_W-1:0] rd_q;
    logic              sel0_q, sel1_q, blank_q;
    logic              fs_q, sa_q;

    logic [15:0]       hcnt_d, vcnt_d;
    logic [ADDR_W-1:0] rd_d;
    logic              line_end, frame_end;
    logic              act_q, act_d;
    logic              swap_d, disp_d, show_d;

    // Next raster position and what will be shown there, assuming the raster advances
    always_comb begin
        line_end  = (hcnt_q == H_LAST);
        frame_end = line_end && (vcnt_q == V_LAST);
        hcnt_d    = line_end ? 16'd0 : hcnt_q + 16'd1;
        vcnt_d    = vcnt_q;
        if (line_end) begin
            vcnt_d = (vcnt_q == V_LAST) ? 16'd0 : vcnt_q + 16'd1;
        end
        act_q  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        act_d  = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
        // A WrDone arriving on the frame-end cycle itself still makes this boundary
        swap_d = frame_end && (pend_q || WrDone);
        disp_d = disp_q;
        if (swap_d) begin
            // The first completed frame always lands in buffer 0
            disp_d = (state_q == S_RUN) ? ~disp_q : 1'b0;
        end
        show_d = ((state_q == S_RUN) || swap_d) && act_d;
        // Address counts visible pixels already shown in this frame
        rd_d   = rd_q;
        if (frame_end) begin
            rd_d = '0;
        end else if (act_q) begin
            rd_d = rd_q + ADDR_W'(1);
        end
    end

    // Raster, swap FSM and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_NOFRAME;
            disp_q  <= 1'b0;
            pend_q  <= 1'b0;
            hcnt_q  <= 16'd0;
            vcnt_q  <= 16'd0;
            rd_q    <= '0;
            sel0_q  <= 1'b0;
            sel1_q  <= 1'b0;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
            sa_q    <= 1'b0;
        end else if (Enable) begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            rd_q    <= rd_d;
            fs_q    <= frame_end;
            sa_q    <= swap_d;
            if (swap_d) begin
                state_q <= S_RUN;
                disp_q  <= disp_d;
                pend_q  <= 1'b0;
            end else if (WrDone) begin
                pend_q  <= 1'b1;
            end
            sel0_q  <= show_d && !disp_d;
            sel1_q  <= show_d && disp_d;
            blank_q <= !show_d;
        end else begin
            // Frozen raster: hold position, blank the output, keep any request
            if (WrDone) begin
                pend_q <= 1'b1;
            end
            sel0_q  <= 1'b0;
            sel1_q  <= 1'b0;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
            sa_q    <= 1'b0;
        end
    end

    assign SelBuf0    = sel0_q;
    assign SelBuf1    = sel1_q;
    assign SelBlank   = blank_q;
    assign RdAddr     = rd_q;
    assign HCount     = hcnt_q;
    assign VCount     = vcnt_q;
    assign FrameStart = fs_q;
    assign SwapAck    = sa_q;

endmodule
